multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Moore-style main controller for the multi-cycle RV32I datapath (shared instr/data memory, IR, OldPC, A/B, ALUOut, Data regs).
//  Sequences fetch/decode/execute/writeback over 3-5 cycles per instruction. Decodes lw, sw, R-ALU, I-ALU, beq, jal.
//  Holds in memory states until mem_ready. Halts on unsupported encodings.
// PARAMETERS
//  CNT_WIDTH        32  width of perf counters (used only with MCU_PERF_CNT_EN)
//  HALT_ON_ILLEGAL  1   1: HALT is sticky until reset; 0: HALT returns to FETCH next cycle
// PORTS
//  clk         in   1  clock, all state on posedge
//  rst         in   1  synchronous reset, ACTIVE-LOW (rst==0 resets at the edge)
//  op          in   7  IR[6:0]
//  funct3      in   3  IR[14:12]
//  funct7_5    in   1  IR[30]
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory access completes this cycle
//  pc_write    out  1  PC load enable
//  adr_src     out  1  0: mem addr=PC, 1: mem addr=Result
//  mem_write   out  1  memory write enable
//  ir_write    out  1  IR and OldPC load enable
//  result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
//  alu_src_a   out  2  00 PC, 01 OldPC, 10 A
//  alu_src_b   out  2  00 B, 01 immExt, 10 const 4
//  imm_src     out  2  00 I, 01 S, 10 B, 11 J (decoded from op)
//  alu_control out  3  000 add, 001 sub, 010 and, 011 or, 100 sra, 101 slt
//  reg_write   out  1  register file write enable
//  halted      out  1  high while in HALT
//  state_o     out  4  current state encoding (debug)
//  cycle_count out  CNT_WIDTH  cycles since reset (0 without macro)
//  instr_count out  CNT_WIDTH  retired instructions (0 without macro)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 EXECI=7 ALUWB=8 BEQ=9 JAL=10 HALT=11.
//  Reset: state=FETCH, halted=0, counters=0. In any cycle with rst==0, pc_write/ir_write/mem_write/reg_write are forced 0.
//  Unlisted outputs are 0 in each state. pc_write = (branch & zero) | pc_update.
//  FETCH: adr_src=0, A=00, B=10, add, result_src=10. ir_write=pc_update=mem_ready. mem_ready=0: stay; else ->DECODE.
//  DECODE: A=01, B=01, add (branch/jal target to ALUOut). op 0000011/0100011->MEMADR; 0110011->EXECR;
//   0010011->EXECI; 1100011->BEQ; 1101111->JAL; any other op ->HALT.
//   ALU-class op with unsupported funct3/funct7_5 ->HALT. Supported: 000 (add; sub if R and f7_5), 010 slt,
//   101 with f7_5=1 (sra/srai), 110 or, 111 and. 101 with f7_5=0 is illegal.
//  MEMADR: A=10, B=01, add. lw->MEMREAD, sw->MEMWRITE.
//  MEMREAD: adr_src=1, result_src=00. Hold until mem_ready, then ->MEMWB. MEMWB: result_src=01, reg_write=1 ->FETCH.
//  MEMWRITE: adr_src=1, result_src=00, mem_write=1 every held cycle. Hold until mem_ready, then ->FETCH.
//  EXECR: A=10, B=00, decoded op ->ALUWB. EXECI: A=10, B=01, decoded op ->ALUWB.
//  ALUWB: result_src=00, reg_write=1 ->FETCH.
//  BEQ: A=10, B=00, sub, result_src=00, branch=1 ->FETCH. JAL: A=01, B=10, add, result_src=00, pc_update=1 ->ALUWB.
//  HALT: all enables 0, halted=1. Exit per HALT_ON_ILLEGAL.
//  alu_control, imm_src are combinational from op/funct in EXECR/EXECI; forced values in other states as listed.
//  Latency with mem_ready=1: R/I/jal 4 cycles, beq 3, sw 4, lw 5. Each mem_ready=0 cycle adds 1.
//  Reset mid-instruction abandons it; no partial writes follow.
// CONFIGURATION
//  MCU_PERF_CNT_EN defined: cycle_count +1 every non-reset, non-HALT cycle.
//   instr_count +1 on each retiring transition into FETCH (ALUWB, MEMWB, BEQ, MEMWRITE with mem_ready). Both saturate at all-ones.
//  Undefined: no counter registers; cycle_count/instr_count tied to 0.
// TESTING
//  add (op=0110011,f3=000,f7_5=0), mem_ready=1 -> states 0,1,6,8,0; alu_control=000 in EXECR; reg_write only in ALUWB.
//  lw, mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, total 8; ir_write=0 throughout; reg_write in MEMWB.
//  beq zero=1 -> pc_write=1 in BEQ with alu_control=001. Same with zero=0 -> pc_write=0; both return to FETCH.
//  op=0110011,f3=101,f7_5=1 -> alu_control=100. f7_5=0 -> HALT, halted=1, held 10 cycles (HALT_ON_ILLEGAL=1).
//  sw with mem_ready=0, rst driven 0 -> next state FETCH, mem_write=0 in the reset cycle; counters cleared.
//  MCU_PERF_CNT_EN, three back-to-back adds with mem_ready=1 -> instr_count=3, cycle_count=12.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main controller for the multi-cycle RV32I datapath: fetch/decode/execute/writeback sequencing.
// Optional perf counters are enabled by defining MCU_PERF_CNT_EN.
module multicycle_control_fsm #(
   parameter int CNT_WIDTH       = 32,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7_5,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic                 adr_src,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic [1:0]           result_src,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           imm_src,
   output logic [2:0]           alu_control,
   output logic                 reg_write,
   output logic                 halted,
   output logic [3:0]           state_o,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instr_count
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_HALT     = 4'd11
   } state_t;

   typedef struct packed {
      logic       adr_src;
      logic       mem_write;
      logic       reg_write;
      logic       branch;
      logic       pc_update;
      logic       fetch;
      logic       exec;
      logic       halted;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
   } ctrl_t;

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl_q;
   logic   alu_legal_s;

   // State-only control word; fetch/exec flags mark the input-dependent terms.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:    begin c.alu_src_b = 2'b10; c.result_src = 2'b10; c.fetch = 1'b1; end
         S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
         S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
         S_MEMREAD:  begin c.adr_src = 1'b1; end
         S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
         S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
         S_EXECR:    begin c.alu_src_a = 2'b10; c.exec = 1'b1; end
         S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.exec = 1'b1; end
         S_ALUWB:    begin c.reg_write = 1'b1; end
         S_BEQ:      begin c.alu_src_a = 2'b10; c.alu_control = 3'b001; c.branch = 1'b1; end
         S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
         S_HALT:     begin c.halted = 1'b1; end
         default:    c = '0;
      endcase
      return c;
   endfunction

   function automatic logic alu_legal(input logic [2:0] f3, input logic f7_5);
      case (f3)
         3'b000, 3'b010, 3'b110, 3'b111: return 1'b1;
         3'b101:                         return f7_5;
         default:                        return 1'b0;
      endcase
   endfunction

   // funct7_5 selects sub only for register-register ops; for I-type it is an immediate bit.
   function automatic logic [2:0] alu_decode(input logic is_r, input logic [2:0] f3, input logic f7_5);
      case (f3)
         3'b000:  return (is_r && f7_5) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b101:  return 3'b100;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   assign alu_legal_s = alu_legal(funct3, funct7_5);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = alu_legal_s ? S_EXECR : S_HALT;
               OP_I:         state_d = alu_legal_s ? S_EXECI : S_HALT;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_HALT;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_HALT:     state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   // State register with the control word registered alongside it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
         ctrl_q  <= state_ctrl(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= state_ctrl(state_d);
      end
   end

   // Write enables are suppressed during any reset cycle so an abandoned instruction leaves no side effects.
   always_comb begin
      pc_write    = rst & ((ctrl_q.branch & zero) | ctrl_q.pc_update | (ctrl_q.fetch & mem_ready));
      ir_write    = rst & ctrl_q.fetch & mem_ready;
      mem_write   = rst & ctrl_q.mem_write;
      reg_write   = rst & ctrl_q.reg_write;
      adr_src     = ctrl_q.adr_src;
      result_src  = ctrl_q.result_src;
      alu_src_a   = ctrl_q.alu_src_a;
      alu_src_b   = ctrl_q.alu_src_b;
      halted      = ctrl_q.halted;
      state_o     = state_q;
      if (ctrl_q.exec) begin
         alu_control = alu_decode(op == OP_R, funct3, funct7_5);
      end else begin
         alu_control = ctrl_q.alu_control;
      end
      case (op)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

`ifdef MCU_PERF_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   logic [CNT_WIDTH-1:0] cycle_q;
   logic [CNT_WIDTH-1:0] instr_q;
   logic                 retire_s;

   assign retire_s = (state_q == S_ALUWB) || (state_q == S_MEMWB) || (state_q == S_BEQ) ||
                     ((state_q == S_MEMWRITE) && mem_ready);

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         if ((state_q != S_HALT) && (cycle_q != {CNT_WIDTH{1'b1}})) begin
            cycle_q <= cycle_q + CNT_ONE;
         end
         if (retire_s && (instr_q != {CNT_WIDTH{1'b1}})) begin
            instr_q <= instr_q + CNT_ONE;
         end
      end
   end

   assign cycle_count = cycle_q;
   assign instr_count = instr_q;
`else
   assign cycle_count = '0;
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-instruction state paths drive a behavioural model.
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        rst, zero, mem_ready, funct7_5;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        pc_write, adr_src, mem_write, ir_write, reg_write, halted;
   logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0]  alu_control;
   logic [3:0]  state_o;
   logic [31:0] cycle_count, instr_count;

   int          vectors = 0;
   int          miscompares = 0;
   int          m_state;
   logic [31:0] m_cyc, m_ins;
   int          tr_state[$], tr_alu[$], tr_rw[$], tr_ir[$], tr_pcw[$], tr_mw[$];

   always #5 clk = ~clk;

   multicycle_control_fsm #(.CNT_WIDTH(32), .HALT_ON_ILLEGAL(1'b1)) dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .imm_src(imm_src), .alu_control(alu_control), .reg_write(reg_write), .halted(halted),
      .state_o(state_o), .cycle_count(cycle_count), .instr_count(instr_count)
   );

   function automatic logic legal_alu(input logic [2:0] f, input logic f7);
      return (f == 3'd0) || (f == 3'd2) || (f == 3'd6) || (f == 3'd7) || ((f == 3'd5) && f7);
   endfunction

   // Expected outputs for a cycle spent in state s.
   function automatic logic [84:0] model(input int s, input logic [6:0] o, input logic [2:0] f,
                                         input logic f7, input logic mr, input logic z, input logic r,
                                         input logic [31:0] cyc, input logic [31:0] ins);
      logic       pcw, adr, mw, irw, rw, hl;
      logic [1:0] rs, a, b, imm;
      logic [2:0] alu;
      logic [2:0] tab [8];
      logic [3:0] s4;
      tab = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd4, 3'd3, 3'd2};
      {pcw, adr, mw, irw, rw, hl} = 6'b0;
      rs = 2'd0; a = 2'd0; b = 2'd0; alu = 3'd0;
      imm = (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 : (o == 7'b1101111) ? 2'd3 : 2'd0;
      case (s)
         0:  begin b = 2'd2; rs = 2'd2; irw = mr; pcw = mr; end
         1:  begin a = 2'd1; b = 2'd1; end
         2:  begin a = 2'd2; b = 2'd1; end
         3:  adr = 1'b1;
         4:  begin rs = 2'd1; rw = 1'b1; end
         5:  begin adr = 1'b1; mw = 1'b1; end
         6:  begin a = 2'd2; alu = (f == 3'd0 && f7) ? 3'd1 : tab[f]; end
         7:  begin a = 2'd2; b = 2'd1; alu = tab[f]; end
         8:  rw = 1'b1;
         9:  begin a = 2'd2; alu = 3'd1; pcw = z; end
         10: begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
         11: hl = 1'b1;
         default: hl = 1'b0;
      endcase
      if (!r) {pcw, mw, irw, rw} = 4'b0;
      s4 = s[3:0];
`ifndef MCU_PERF_CNT_EN
      cyc = 32'd0;
      ins = 32'd0;
`endif
      return {pcw, adr, mw, irw, rs, a, b, imm, alu, rw, hl, s4, cyc, ins};
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   // One clock cycle in model state m_state; entered and left at posedge+1.
   task automatic step(input logic mr, input logic z, input logic r);
      logic [84:0] act, exp;
      mem_ready = mr; zero = z; rst = r;
      @(negedge clk);
      exp = model(m_state, op, funct3, funct7_5, mr, z, r, m_cyc, m_ins);
      act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, imm_src,
             alu_control, reg_write, halted, state_o, cycle_count, instr_count};
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL cycle_vec t=%0t model_state=%0d got=%h exp=%h", $time, m_state, act, exp);
      end
      tr_state.push_back(int'(state_o)); tr_alu.push_back(int'(alu_control));
      tr_rw.push_back(int'(reg_write)); tr_ir.push_back(int'(ir_write));
      tr_pcw.push_back(int'(pc_write)); tr_mw.push_back(int'(mem_write));
      if (!r) begin
         m_cyc = 32'd0; m_ins = 32'd0;
      end else begin
         if (m_state != 11) m_cyc++;
         if (m_state == 8 || m_state == 4 || m_state == 9 || (m_state == 5 && mr)) m_ins++;
      end
      @(posedge clk); #1;
   endtask

   task automatic clear_trace();
      tr_state.delete(); tr_alu.delete(); tr_rw.delete();
      tr_ir.delete(); tr_pcw.delete(); tr_mw.delete();
   endtask

   // Runs one instruction; stall <0 means random, abort -1 none / -2 random / else path index.
   task automatic instr(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic z,
                        input int fstall, input int mstall, input int abort, input int halt_cycles);
      int path[$];
      int ab, n;
      op = o; funct3 = f; funct7_5 = f7;
      path = '{0, 1};
      case (o)
         7'b0000011: path = {path, 2, 3, 4};
         7'b0100011: path = {path, 2, 5};
         7'b0110011: path = legal_alu(f, f7) ? {path, 6, 8} : {path, 11};
         7'b0010011: path = legal_alu(f, f7) ? {path, 7, 8} : {path, 11};
         7'b1100011: path = {path, 9};
         7'b1101111: path = {path, 10, 8};
         default:    path = {path, 11};
      endcase
      ab = abort;
      if (abort == -2) ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, path.size() - 1)) : -1;
      foreach (path[i]) begin
         m_state = path[i];
         if (i == ab) begin
            step(1'($urandom_range(0, 1)), z, 1'b0);
            m_state = 0;
            return;
         end
         if (m_state == 0 || m_state == 3 || m_state == 5) begin
            n = (m_state == 0) ? fstall : mstall;
            if (n < 0) n = $urandom_range(0, 2);
            repeat (n) step(1'b0, z, 1'b1);
            step(1'b1, z, 1'b1);
         end else begin
            step(1'($urandom_range(0, 1)), z, 1'b1);
         end
      end
      if (m_state == 11) begin
         repeat (halt_cycles) step(1'($urandom_range(0, 1)), z, 1'b1);
         step(1'b0, z, 1'b0);
      end
      m_state = 0;
   endtask

   initial begin
      int exp_add[4];
      int exp_lw[8];
      int cnt;
      logic [6:0] ro;
      exp_add = '{0, 1, 6, 8};
      exp_lw  = '{0, 1, 2, 3, 3, 3, 3, 4};
      rst = 1'b0; zero = 1'b0; mem_ready = 1'b0; op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_state = 0; m_cyc = 32'd0; m_ins = 32'd0;
      step(1'b1, 1'b0, 1'b0);

      // add: path and ALU op
      clear_trace();
      instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, -1, 0);
      chk("add_len", tr_state.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("add_state%0d", i), tr_state[i], exp_add[i]);
      chk("add_alu_execr", tr_alu[2], 0);
      chk("add_regwrite", tr_rw[0] + tr_rw[1] + tr_rw[2], 0);
      chk("add_regwrite_aluwb", tr_rw[3], 1);

      // lw with a three-cycle memory stall
      clear_trace();
      instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, -1, 0);
      chk("lw_len", tr_state.size(), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("lw_state%0d", i), tr_state[i], exp_lw[i]);
      cnt = 0;
      foreach (tr_ir[i]) cnt += tr_ir[i];
      chk("lw_irwrite_once", cnt, 1);
      chk("lw_regwrite_memwb", tr_rw[7], 1);

      // beq taken and not taken
      clear_trace();
      instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, -1, 0);
      chk("beq_t_state", tr_state[2], 9);
      chk("beq_t_pcwrite", tr_pcw[2], 1);
      chk("beq_t_alu", tr_alu[2], 1);
      clear_trace();
      instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, -1, 0);
      chk("beq_nt_pcwrite", tr_pcw[2], 0);

      // sra and the illegal f7_5=0 variant
      clear_trace();
      instr(7'b0110011, 3'b101, 1'b1, 1'b0, 0, 0, -1, 0);
      chk("sra_alu", tr_alu[2], 4);
      clear_trace();
      instr(7'b0110011, 3'b101, 1'b0, 1'b0, 0, 0, -1, 10);
      cnt = 0;
      foreach (tr_state[i]) cnt += (tr_state[i] == 11) ? 1 : 0;
      chk("illegal_halt_cycles", cnt, 12);

      // sw interrupted by reset while waiting on memory
      clear_trace();
      instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 3, 0);
      chk("sw_rst_state", tr_state[3], 5);
      chk("sw_rst_memwrite", tr_mw[3], 0);
      chk("sw_rst_next_fetch", state_o, 0);
      chk("sw_rst_cycle_cnt", cycle_count, 0);
      chk("sw_rst_instr_cnt", instr_count, 0);

      // three back-to-back adds from a clean counter state
      for (int k = 0; k < 3; k++) instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, -1, 0);
`ifdef MCU_PERF_CNT_EN
      chk("adds3_cycle_cnt", cycle_count, 12);
      chk("adds3_instr_cnt", instr_count, 3);
`else
      chk("adds3_cycle_cnt", cycle_count, 0);
      chk("adds3_instr_cnt", instr_count, 0);
`endif

      // randomized instruction stream
      for (int k = 0; k < 250; k++) begin
         case ($urandom_range(0, 7))
            0: ro = 7'b0000011;
            1: ro = 7'b0100011;
            2, 7: ro = 7'b0110011;
            3: ro = 7'b0010011;
            4: ro = 7'b1100011;
            5: ro = 7'b1101111;
            default: ro = 7'($urandom_range(0, 127));
         endcase
         instr(ro, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               -1, -1, -2, int'($urandom_range(1, 4)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
